// File: rtl/ov7670_dvp_tx.sv
// rtl/ov7670_dvp_tx.sv - OV7670-style DVP camera source for in-fabric loopback
//
// Purpose: emulates the OV7670 parallel video port. It produces c_VSYNC/c_HREF/
// c_PCLK/c_DOUT framing and serializes RGB565 pixels high byte first.
//
// Ports:
//   clk_25MHz   sole clock; c_PCLK is clk_25MHz/2
//   rst_n       asynchronous active-low reset
//   enable      run frames while high; a frame in flight always completes
//   px_data     RGB565 pixel from upstream
//   px_valid    px_data holds a pixel
//   px_ready    one-cycle pulse: px_data was latched (consumed) this cycle
//   c_PCLK      byte clock; data is stable across its rising edge
//   c_HREF      line-active qualifier
//   c_VSYNC     frame sync, active high
//   c_DOUT      byte data (0 outside active bytes)
//   frame_done  one-cycle pulse when the front porch ends
//   underflow   sticky: a pixel was due while px_valid was low; clears at VSYNC
//
// Optional feature: define OV7670_DVP_TX_TEST_PATTERN_EN to replace the pixel
// stream with 8 internal vertical colour bars (px_ready held 0, underflow 0).
module ov7670_dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic        c_PCLK,
  output logic        c_HREF,
  output logic        c_VSYNC,
  output logic [7:0]  c_DOUT,
  output logic        frame_done,
  output logic        underflow
);

  localparam int LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
  localparam int ACT_BYTES  = 2 * H_ACTIVE;
  localparam int BYTE_W     = $clog2(LINE_BYTES);
  localparam int LINE_W     = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_V_BACK,
    S_ACTIVE,
    S_V_FRONT
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic                phase;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [BYTE_W-1:0]   nxt_byte;
  logic [LINE_W-1:0]   line_cnt;
  logic [LINE_W-1:0]   nxt_line;
  logic [LINE_W-1:0]   state_len;
  logic                frame_end;
  logic                nxt_active;
  logic                nxt_hi;
  logic [7:0]          lo_byte;
  logic [15:0]         src_data;
  logic                src_valid;

  assign c_PCLK = phase;

  always_comb begin
    state_len = '0;
    case (state)
      S_VSYNC:   state_len = LINE_W'(VSYNC_LINES);
      S_V_BACK:  state_len = LINE_W'(V_BACK);
      S_ACTIVE:  state_len = LINE_W'(V_ACTIVE);
      S_V_FRONT: state_len = LINE_W'(V_FRONT);
      default:   state_len = '0;
    endcase
  end

  // Position of the byte period that the next phase-0 entry will launch.
  always_comb begin
    nxt_state = state;
    nxt_byte  = byte_cnt;
    nxt_line  = line_cnt;
    frame_end = 1'b0;
    if (state == S_IDLE) begin
      if (enable) nxt_state = S_VSYNC;
    end else if (byte_cnt == BYTE_W'(LINE_BYTES - 1)) begin
      nxt_byte = '0;
      if (line_cnt == state_len - LINE_W'(1)) begin
        nxt_line = '0;
        case (state)
          S_VSYNC:  nxt_state = S_V_BACK;
          S_V_BACK: nxt_state = S_ACTIVE;
          S_ACTIVE: nxt_state = S_V_FRONT;
          default: begin
            frame_end = 1'b1;
            nxt_state = enable ? S_VSYNC : S_IDLE;
          end
        endcase
      end else begin
        nxt_line = line_cnt + LINE_W'(1);
      end
    end else begin
      nxt_byte = byte_cnt + BYTE_W'(1);
    end
  end

  assign nxt_active = (nxt_state == S_ACTIVE) && (nxt_byte < BYTE_W'(ACT_BYTES));
  assign nxt_hi     = nxt_active && !nxt_byte[0];

`ifdef OV7670_DVP_TX_TEST_PATTERN_EN
  localparam bit USE_STREAM = 1'b0;
  localparam int BAR_BYTES  = 2 * (H_ACTIVE / 8);

  logic [2:0] tp_bar;
  wire        unused_stream = &{1'b0, px_data, px_valid};

  // Bar index from the byte position: count the bar boundaries already passed.
  always_comb begin
    tp_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(nxt_byte) >= k * BAR_BYTES) tp_bar = 3'(k);
    end
  end

  always_comb begin
    src_valid = 1'b1;
    case (tp_bar)
      3'd0:    src_data = 16'hFFFF;
      3'd1:    src_data = 16'hFFE0;
      3'd2:    src_data = 16'h07FF;
      3'd3:    src_data = 16'h07E0;
      3'd4:    src_data = 16'hF81F;
      3'd5:    src_data = 16'hF800;
      3'd6:    src_data = 16'h001F;
      default: src_data = 16'h0000;
    endcase
  end
`else
  localparam bit USE_STREAM = 1'b1;

  assign src_data  = px_data;
  assign src_valid = px_valid;
`endif

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      c_HREF     <= 1'b0;
      c_VSYNC    <= 1'b0;
      c_DOUT     <= 8'h00;
      lo_byte    <= 8'h00;
      px_ready   <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      phase      <= ~phase;
      px_ready   <= 1'b0;
      frame_done <= 1'b0;
      // All video outputs move only on the edge entering phase 0 (c_PCLK falling).
      if (phase) begin
        state      <= nxt_state;
        byte_cnt   <= nxt_byte;
        line_cnt   <= nxt_line;
        c_VSYNC    <= (nxt_state == S_VSYNC);
        c_HREF     <= nxt_active;
        frame_done <= frame_end;
        if ((nxt_state == S_VSYNC) && (state != S_VSYNC)) underflow <= 1'b0;
        if (nxt_hi) begin
          if (src_valid) begin
            c_DOUT   <= src_data[15:8];
            lo_byte  <= src_data[7:0];
            px_ready <= USE_STREAM;
          end else begin
            // Starved pixel: emit zeros and leave the pending pixel unconsumed.
            c_DOUT    <= 8'h00;
            lo_byte   <= 8'h00;
            underflow <= 1'b1;
          end
        end else if (nxt_active) begin
          c_DOUT <= lo_byte;
        end else begin
          c_DOUT <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// tb/tb_ov7670_dvp_tx.sv - self-checking bench for ov7670_dvp_tx
`timescale 1ns/1ps
module tb_ov7670_dvp_tx;

  localparam int H_ACTIVE    = 8;
  localparam int H_BLANK     = 2;
  localparam int V_ACTIVE    = 2;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LINE_CLK    = 4 * (H_ACTIVE + H_BLANK);
  localparam int FRAME_CLK   = LINE_CLK * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
  localparam int FIRST_ACT   = VSYNC_LINES + V_BACK;

`ifdef OV7670_DVP_TX_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk_25MHz = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        c_PCLK;
  logic        c_HREF;
  logic        c_VSYNC;
  logic [7:0]  c_DOUT;
  logic        frame_done;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] pixels [0:255];
  int          drv_idx;
  int          m_idx;
  int          lat;

  ov7670_dvp_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .enable(enable),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .c_PCLK(c_PCLK), .c_HREF(c_HREF), .c_VSYNC(c_VSYNC), .c_DOUT(c_DOUT),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [15:0] bar_color(input int b);
    case (b)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Is the byte period at frame clock u the launch of a pixel, and which one?
  function automatic int pixel_at(input int u);
    int line;
    int bp;
    line = u / LINE_CLK;
    bp   = (u % LINE_CLK) / 2;
    if (u < FRAME_CLK && u % 2 == 0 && line >= FIRST_ACT && line < FIRST_ACT + V_ACTIVE &&
        bp < 2 * H_ACTIVE && bp % 2 == 0)
      return (line - FIRST_ACT) * H_ACTIVE + bp / 2;
    return -1;
  endfunction

  task automatic wait_vsync(output int n);
    n = 0;
    while (!c_VSYNC && n < 50) begin
      @(posedge clk_25MHz);
      #1;
      n++;
    end
  endtask

  // Checks one whole frame sample-by-sample against the frame timing rules.
  // t=0 is the first falling clk edge after c_VSYNC rose.
  task automatic run_frame(input int drop, input bit fd_first, input int en_off_t);
    logic [15:0] exp_pix;
    bit          uf;
    exp_pix = 16'h0000;
    uf      = 1'b0;
    for (int t = 0; t < FRAME_CLK; t++) begin
      int         line;
      int         bp;
      int         ph;
      int         pix;
      logic       exp_vs;
      logic       exp_href;
      logic       exp_rdy;
      logic [7:0] exp_dout;
      @(negedge clk_25MHz);
      line     = t / LINE_CLK;
      bp       = (t % LINE_CLK) / 2;
      ph       = t % 2;
      exp_vs   = (line < VSYNC_LINES);
      exp_href = (line >= FIRST_ACT) && (line < FIRST_ACT + V_ACTIVE) && (bp < 2 * H_ACTIVE);
      exp_rdy  = 1'b0;
      pix      = pixel_at(t);
      if (pix >= 0) begin
        if (TP) begin
          exp_pix = bar_color((bp / 2) / (H_ACTIVE / 8));
        end else if (pix == drop) begin
          exp_pix = 16'h0000;
          uf      = 1'b1;
        end else begin
          exp_pix = pixels[m_idx];
          m_idx++;
          exp_rdy = 1'b1;
        end
      end
      exp_dout = !exp_href ? 8'h00 : ((bp % 2 == 0) ? exp_pix[15:8] : exp_pix[7:0]);
      check("sync_vs_href_pclk", t, 32'({c_VSYNC, c_HREF, c_PCLK}), 32'({exp_vs, exp_href, ph[0]}));
      check("dout", t, 32'(c_DOUT), 32'(exp_dout));
      check("ready_uf_fd", t, 32'({px_ready, underflow, frame_done}),
            32'({exp_rdy, uf, (t == 0) ? fd_first : 1'b0}));
      // Upstream side: advance on a handshake, starve the chosen pixel.
      if (t == en_off_t) enable = 1'b0;
      if (px_ready) drv_idx++;
      px_data  = pixels[drv_idx];
      px_valid = 1'b1;
      if (drop >= 0 && pixel_at(t + 1) == drop) px_valid = 1'b0;
    end
  endtask

  task automatic check_idle_after_last(input string tag);
    @(negedge clk_25MHz);
    check({tag, "_frame_done"}, 0, 32'(frame_done), 32'd1);
    for (int i = 1; i < 60; i++) begin
      @(negedge clk_25MHz);
      check({tag, "_idle"}, i, 32'({c_VSYNC, c_HREF, c_DOUT, px_ready, frame_done}), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    enable   = 1'b0;
    px_valid = 1'b1;
    for (int i = 0; i < 256; i++) pixels[i] = 16'($urandom);
    pixels[0] = 16'h1234;
    pixels[1] = 16'h5678;
    px_data   = pixels[0];
    drv_idx   = 0;
    m_idx     = 0;

    repeat (3) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    check("reset_outputs", 0,
          32'({c_PCLK, c_HREF, c_VSYNC, c_DOUT, px_ready, frame_done, underflow}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_25MHz);
      check("idle_no_enable", i, 32'({c_VSYNC, c_HREF, c_DOUT, px_ready, frame_done, underflow}), 32'd0);
    end

    // Frame 1: continuous stream, first pixels 0x1234 then 0x5678.
    enable = 1'b1;
    wait_vsync(lat);
    check("vsync_latency_ok", lat, 32'(lat >= 1 && lat <= 2), 32'd1);
    run_frame(-1, 1'b0, -1);
    // Frame 2: third pixel of line 0 starved.
    run_frame(2, 1'b1, -1);
    // Frame 3: underflow cleared by the VSYNC entry.
    run_frame(-1, 1'b1, -1);
    // Frame 4: enable dropped during active line 1; frame still completes.
    run_frame(-1, 1'b1, 3 * LINE_CLK + 10);
    check_idle_after_last("enable_drop");

    // Mid-frame reset during an active byte.
    enable = 1'b1;
    wait_vsync(lat);
    check("vsync_latency_ok2", lat, 32'(lat >= 1 && lat <= 2), 32'd1);
    n = 0;
    while (!c_HREF && n < FRAME_CLK) begin
      @(posedge clk_25MHz);
      #1;
      n++;
    end
    check("href_reached", n, 32'(c_HREF), 32'd1);
    @(negedge clk_25MHz);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 0,
          32'({c_PCLK, c_HREF, c_VSYNC, c_DOUT, px_ready, frame_done, underflow}), 32'd0);
    @(negedge clk_25MHz);
    rst_n    = 1'b1;
    m_idx    = drv_idx;
    px_data  = pixels[drv_idx];
    px_valid = 1'b1;
    wait_vsync(lat);
    check("vsync_latency_after_reset", 0, 32'(lat), 32'd2);
    run_frame(-1, 1'b0, 4 * LINE_CLK + 5);
    check_idle_after_last("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
